// File: rtl/posit_decoder_pipe_if.sv
// posit_decoder_pipe_if: handshake and decoded-field bundle for the posit decoder
// master: word source and result sink (drives in_data/in_vld/out_rdy)
// slave: decoder (drives in_rdy, out_vld and decoded fields)
// out_exp is kept one bit wide and tied to 0 when ES=0
interface posit_decoder_pipe_if #(
  parameter int N = 8,
  parameter int ES = 2
);
  localparam int RW = $clog2(N) + 1;
  localparam int MW = N - 3 - ES;
  localparam int SW = RW + ES;
  localparam int EW = (ES > 0) ? ES : 1;
  logic [N-1:0] in_data;
  logic in_vld;
  logic in_rdy;
  logic out_vld;
  logic out_rdy;
  logic out_sign;
  logic signed [RW-1:0] out_regime;
  logic [EW-1:0] out_exp;
  logic [MW:0] out_mant;
  logic signed [SW-1:0] out_scale;
  logic [1:0] out_type;
  modport master (
    output in_data, in_vld, out_rdy,
    input in_rdy, out_vld, out_sign, out_regime, out_exp, out_mant, out_scale, out_type
  );
  modport slave (
    input in_data, in_vld, out_rdy,
    output in_rdy, out_vld, out_sign, out_regime, out_exp, out_mant, out_scale, out_type
  );
endinterface

// File: rtl/posit_decoder_pipe.sv
// posit_decoder_pipe: 3-stage pipelined posit field decoder with valid/ready flow control
// clk_i/rst_i: clock and synchronous active-high reset
// bus: in_data/in_vld/in_rdy input handshake; out_vld/out_rdy plus decoded sign, regime, exp, mant, scale, type
module posit_decoder_pipe #(
  parameter int N = 8,
  parameter int ES = 2
) (
  input logic clk_i,
  input logic rst_i,
  posit_decoder_pipe_if.slave bus
);
  localparam int RW = $clog2(N) + 1;
  localparam int MW = N - 3 - ES;
  localparam int SW = RW + ES;
  localparam int EW = (ES > 0) ? ES : 1;
  logic v1, v2, v3, en1, en2, en3;
  logic s1, s2;
  logic [N-2:0] m1;
  logic [1:0] t2;
  logic signed [RW-1:0] k2, k;
  logic [RW-1:0] r2, r;
  logic [N-4:0] f2, ef;
  logic [EW-1:0] e;
  logic signed [SW-1:0] sc;
  logic run, norm;
  assign en3 = !v3 || bus.out_rdy;
  assign en2 = !v2 || en3;
  assign en1 = !v1 || en2;
  assign bus.in_rdy = en1;
  assign bus.out_vld = v3;
  always_comb begin
    r = RW'(1);
    run = 1'b1;
    for (int i = N - 3; i >= 0; i--) begin
      run = run && (m1[i] == m1[N-2]);
      r = r + RW'(run);
    end
    k = m1[N-2] ? $signed(r - RW'(1)) : -$signed(r);
  end
  // S2 keeps only the bits below the first run bit and its neighbour; since the
  // run is at least one bit long, shifting by r-1 drops the rest of the run and
  // the terminator, with zeros filling in past the end of the word.
  assign ef = f2 << (r2 - RW'(1));
  generate
    if (ES > 0) begin : g_e
      assign e = ef[N-4 -: ES];
    end else begin : g_ne
      assign e = '0;
    end
  endgenerate
  assign sc = $signed((SW'(k2) <<< ES) + SW'(e));
  assign norm = t2 == 2'b01;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      {v1, v2, v3, s1, s2, m1, t2, k2, r2, f2} <= '0;
      bus.out_sign <= 1'b0;
      bus.out_regime <= '0;
      bus.out_exp <= '0;
      bus.out_mant <= '0;
      bus.out_scale <= '0;
      bus.out_type <= 2'b00;
    end else begin
      if (en1) v1 <= bus.in_vld;
      if (en1 && bus.in_vld) begin
        s1 <= bus.in_data[N-1];
        m1 <= bus.in_data[N-1] ? -bus.in_data[N-2:0] : bus.in_data[N-2:0];
      end
      if (en2) v2 <= v1;
      if (en2 && v1) begin
        s2 <= s1;
        t2 <= ~|m1 ? {s1, 1'b0} : 2'b01;
        k2 <= k;
        r2 <= r;
        f2 <= m1[N-4:0];
      end
      if (en3) v3 <= v2;
      if (en3 && v2) begin
        bus.out_sign <= s2;
        bus.out_regime <= norm ? k2 : '0;
        bus.out_exp <= norm ? e : '0;
        bus.out_mant <= norm ? {1'b1, ef[MW-1:0]} : '0;
        bus.out_scale <= norm ? sc : '0;
        bus.out_type <= t2;
      end
    end
  end
endmodule

// File: tb/tb_posit_decoder_pipe.sv
// tb_posit_decoder_pipe: directed and random scoreboard bench for posit_decoder_pipe (N=8, ES=2)
module tb_posit_decoder_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic rnd = 1'b0;
  logic held = 1'b0;
  logic [18:0] snap;
  logic [18:0] exp_v;
  logic [18:0] q[$];
  logic [7:0] w;
  logic [7:0] ws[6];
  posit_decoder_pipe_if #(.N(8), .ES(2)) bus ();
  posit_decoder_pipe #(.N(8), .ES(2)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [18:0] pk(input logic s, input int k, input int e, input int m, input int sc, input logic [1:0] t);
    return {s, k[3:0], e[1:0], m[3:0], sc[5:0], t};
  endfunction
  function automatic logic [18:0] obs();
    return {bus.out_sign, bus.out_regime, bus.out_exp, bus.out_mant, bus.out_scale, bus.out_type};
  endfunction
  function automatic logic [18:0] model(input logic [7:0] x);
    logic [7:0] v;
    logic b;
    int i, r, k, e, f;
    if (x == 8'h00) return pk(0, 0, 0, 0, 0, 2'b00);
    if (x == 8'h80) return pk(1, 0, 0, 0, 0, 2'b10);
    v = x[7] ? -x : x;
    i = 6;
    b = v[6];
    r = 0;
    while (i >= 0 && v[i] == b) begin
      r++;
      i--;
    end
    k = b ? r - 1 : -r;
    i--;
    e = 0;
    repeat (2) begin
      e = e * 2 + ((i >= 0) ? int'(v[i]) : 0);
      i--;
    end
    f = 0;
    repeat (3) begin
      f = f * 2 + ((i >= 0) ? int'(v[i]) : 0);
      i--;
    end
    return pk(x[7], k, e, 8 + f, k * 4 + e, 2'b01);
  endfunction
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] x);
    checks++;
    assert (o === x) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, x);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d, input logic [18:0] x);
    int n;
    logic done;
    n = 0;
    done = 1'b0;
    bus.in_data = d;
    bus.in_vld = 1'b1;
    while (!done) begin
      if (rnd) bus.out_rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.in_rdy) begin
        q.push_back(x);
        done = 1'b1;
      end else if (n > 50) begin
        chk("send_timeout", 0, 1);
        done = 1'b1;
      end
      n++;
      step();
    end
    bus.in_vld = 1'b0;
  endtask
  task automatic lat_chk(input string tag);
    int l;
    logic seen;
    l = 1;
    seen = 1'b0;
    while (!seen && l < 10) begin
      @(negedge clk);
      if (bus.out_vld) seen = 1'b1;
      else begin
        @(posedge clk);
        l++;
      end
    end
    chk(tag, l, 3);
    step();
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    chk("drain", q.size(), 0);
  endtask
  initial begin
    bus.in_data = '0;
    bus.in_vld = 1'b0;
    bus.out_rdy = 1'b0;
    fork
      forever begin
        @(negedge clk);
        if (rst) held = 1'b0;
        else begin
          if (held && bus.out_vld) chk("hold_stable", obs(), snap);
          if (bus.out_vld && bus.out_rdy) begin
            if (q.size() == 0) chk("unexpected_out", 1, 0);
            else begin
              exp_v = q.pop_front();
              chk("data", obs(), exp_v);
            end
          end
          held = bus.out_vld && !bus.out_rdy;
          snap = obs();
        end
      end
    join_none
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_vld", bus.out_vld, 0);
    chk("rst_out_type", bus.out_type, 0);
    chk("rst_in_rdy", bus.in_rdy, 1);
    step();
    bus.out_rdy = 1'b1;
    send(8'h40, pk(0, 0, 0, 8, 0, 2'b01));
    lat_chk("latency_0x40");
    drain();
    send(8'h5A, pk(0, 0, 3, 10, 3, 2'b01));
    send(8'h7F, pk(0, 6, 0, 8, 24, 2'b01));
    send(8'h01, pk(0, -6, 0, 8, -24, 2'b01));
    send(8'hC0, pk(1, 0, 0, 8, 0, 2'b01));
    send(8'h00, pk(0, 0, 0, 0, 0, 2'b00));
    send(8'h80, pk(1, 0, 0, 0, 0, 2'b10));
    drain();
    foreach (ws[i]) ws[i] = 8'($urandom_range(0, 255));
    send(ws[0], model(ws[0]));
    bus.out_rdy = 1'b0;
    send(ws[1], model(ws[1]));
    send(ws[2], model(ws[2]));
    @(negedge clk);
    chk("full_in_rdy", bus.in_rdy, 0);
    chk("full_out_vld", bus.out_vld, 1);
    repeat (3) step();
    @(negedge clk);
    chk("full_in_rdy_hold", bus.in_rdy, 0);
    step();
    bus.out_rdy = 1'b1;
    @(negedge clk);
    chk("in_rdy_follows_out_rdy", bus.in_rdy, 1);
    step();
    for (int i = 3; i < 6; i++) send(ws[i], model(ws[i]));
    drain();
    bus.out_rdy = 1'b0;
    send(8'h40, model(8'h40));
    send(8'h7F, model(8'h7F));
    send(8'h01, model(8'h01));
    rst = 1'b1;
    step();
    q.delete();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_vld", bus.out_vld, 0);
    chk("midrst_in_rdy", bus.in_rdy, 1);
    step();
    bus.out_rdy = 1'b1;
    repeat (4) step();
    send(8'h5A, pk(0, 0, 3, 10, 3, 2'b01));
    lat_chk("latency_after_rst");
    drain();
    rnd = 1'b1;
    for (int i = 0; i < 40; i++) begin
      w = 8'($urandom_range(0, 255));
      send(w, model(w));
    end
    rnd = 1'b0;
    bus.out_rdy = 1'b1;
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
